// File: rtl/gb_frame_scanout_if.sv
// Framebuffer port of the Game Boy scanout: RAM read bus plus the
// double-buffer bank handshake with the frame writer.
interface gb_frame_scanout_if;
  logic [14:0] fb_addr;
  logic [1:0]  fb_data;
  logic        fb_bank;
  logic        frame_done;
  logic        frame_ack;

  modport master (
    output fb_addr, fb_bank, frame_ack,
    input  fb_data, frame_done
  );

  modport slave (
    input  fb_addr, fb_bank, frame_ack,
    output fb_data, frame_done
  );
endinterface

// File: rtl/gb_frame_scanout.sv
// 160x144 2bpp framebuffer scanout, scaled 3x and centred in 640x480,
// with palette mapping and frame-start double-buffer bank swap.
//
// bank FSM:
//   state        | meaning
//   BANK_IDLE    | no completed bank waiting; next frame start re-displays
//   BANK_PENDING | writer finished a bank; swap at next cx==0 && cy==0
module gb_frame_scanout #(
  parameter int          X_START    = 80,
  parameter int          Y_START    = 24,
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input  logic                       clk_pixel,
  input  logic                       reset_n,
  input  logic [9:0]                 cx,
  input  logic [9:0]                 cy,
  input  logic                       palette_sel,
  output logic [23:0]                rgb,
  gb_frame_scanout_if.master         fb
);

  localparam logic [9:0]  X_LO    = 10'(X_START);
  localparam logic [9:0]  X_HI    = 10'(X_START + 480);
  localparam logic [9:0]  Y_LO    = 10'(Y_START);
  localparam logic [9:0]  Y_HI    = 10'(Y_START + 432);
  localparam logic [7:0]  COL_MAX = 8'd159;
  localparam logic [14:0] ROW_MAX = 15'd22880;

  typedef enum logic {BANK_IDLE, BANK_PENDING} bank_state_t;

  logic [7:0]  col_cnt;
  logic [1:0]  col_sub;
  logic [14:0] row_base;
  logic [1:0]  row_sub;
  logic        row_valid;
  logic        win_d1;
  logic        win_d2;

  logic        x_in;
  logic        y_in;
  logic        win_now;
  logic        col_first;
  logic [7:0]  col_eff;
  logic [1:0]  sub_eff;
  logic [14:0] pix_addr;
  logic [23:0] pal_rgb;

  bank_state_t state;
  bank_state_t state_nxt;
  logic        bank_nxt;
  logic        ack_nxt;
  logic        swap_pt;

  // row_valid keeps a mid-frame reset from producing partial-row addresses
  assign x_in      = (cx >= X_LO) && (cx < X_HI);
  assign y_in      = (cy >= Y_LO) && (cy < Y_HI);
  assign win_now   = x_in && y_in && row_valid;
  assign col_first = (cx == X_LO);
  assign col_eff   = col_first ? 8'd0 : col_cnt;
  assign sub_eff   = col_first ? 2'd0 : col_sub;
  assign pix_addr  = row_base + {7'd0, col_eff};
  assign swap_pt   = (cx == 10'd0) && (cy == 10'd0);

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      col_cnt    <= '0;
      col_sub    <= '0;
      row_base   <= '0;
      row_sub    <= '0;
      row_valid  <= 1'b0;
      fb.fb_addr <= '0;
      win_d1     <= 1'b0;
      win_d2     <= 1'b0;
    end else begin
      if (x_in) begin
        if (sub_eff == 2'd2) begin
          col_sub <= 2'd0;
          col_cnt <= (col_eff == COL_MAX) ? COL_MAX : col_eff + 8'd1;
        end else begin
          col_sub <= sub_eff + 2'd1;
          col_cnt <= col_eff;
        end
      end
      if (cx == 10'd0) begin
        if (cy == Y_LO) begin
          row_base  <= '0;
          row_sub   <= '0;
          row_valid <= 1'b1;
        end else if (y_in && row_valid) begin
          if (row_sub == 2'd2) begin
            row_sub <= 2'd0;
            if (row_base != ROW_MAX) row_base <= row_base + 15'd160;
          end else begin
            row_sub <= row_sub + 2'd1;
          end
        end
      end
      if (win_now) fb.fb_addr <= pix_addr;
      win_d1 <= win_now;
      win_d2 <= win_d1;
    end
  end

  always_comb begin
    pal_rgb = 24'h000000;
    case ({palette_sel, fb.fb_data})
      3'b000: pal_rgb = 24'hFFFFFF;
      3'b001: pal_rgb = 24'hAAAAAA;
      3'b010: pal_rgb = 24'h555555;
      3'b011: pal_rgb = 24'h000000;
      3'b100: pal_rgb = 24'h9BBC0F;
      3'b101: pal_rgb = 24'h8BAC0F;
      3'b110: pal_rgb = 24'h306230;
      3'b111: pal_rgb = 24'h0F380F;
      default: pal_rgb = 24'h000000;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) rgb <= '0;
    else          rgb <= win_d2 ? pal_rgb : BORDER_RGB;
  end

  // a frame_done landing on the swap cycle is consumed by that swap
  always_comb begin
    state_nxt = state;
    bank_nxt  = fb.fb_bank;
    ack_nxt   = 1'b0;
    if (swap_pt && (state == BANK_PENDING || fb.frame_done)) begin
      state_nxt = BANK_IDLE;
      bank_nxt  = ~fb.fb_bank;
      ack_nxt   = 1'b1;
    end else if (fb.frame_done) begin
      state_nxt = BANK_PENDING;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state        <= BANK_IDLE;
      fb.fb_bank   <= 1'b0;
      fb.frame_ack <= 1'b0;
    end else begin
      state        <= state_nxt;
      fb.fb_bank   <= bank_nxt;
      fb.frame_ack <= ack_nxt;
    end
  end

endmodule

// File: tb/tb_gb_frame_scanout.sv
// Directed bench for gb_frame_scanout: compressed raster with address and
// colour probes, palette switching, bank-swap scenarios and mid-frame reset.
module tb_gb_frame_scanout;
  localparam logic [23:0] BORDER = 24'h123456;

  logic        clk_pixel = 1'b0;
  logic        reset_n   = 1'b1;
  logic [9:0]  cx        = '0;
  logic [9:0]  cy        = '0;
  logic        palette_sel = 1'b0;
  logic [23:0] rgb;

  gb_frame_scanout_if fb_if ();

  gb_frame_scanout #(
    .X_START    (80),
    .Y_START    (24),
    .BORDER_RGB (BORDER)
  ) dut (
    .clk_pixel   (clk_pixel),
    .reset_n     (reset_n),
    .cx          (cx),
    .cy          (cy),
    .palette_sel (palette_sel),
    .rgb         (rgb),
    .fb          (fb_if.master)
  );

  always #5 clk_pixel = ~clk_pixel;

  logic       force_en  = 1'b0;
  logic [1:0] force_val = 2'd0;
  logic [1:0] ram_q     = 2'd0;

  always @(posedge clk_pixel) ram_q <= force_en ? force_val : fb_if.fb_addr[1:0];
  assign fb_if.fb_data = ram_q;

  int   n_checks = 0;
  int   n_errors = 0;
  int   hx[3] = '{-1, -1, -1};
  int   hy[3] = '{-1, -1, -1};
  bit   probes_on = 1'b1;
  bit   post_rst  = 1'b0;
  int   ack_cnt   = 0;
  logic exp_bank  = 1'b0;

  int          pa_x[5] = '{80, 82, 83, 84, 559};
  int          pa_y[5] = '{24, 24, 27, 30, 455};
  int          pa_e[5] = '{0, 0, 161, 321, 23039};
  int          pr_x[9] = '{80, 79, 78, 83, 85, 559, 560, 80, 80};
  int          pr_y[9] = '{24, 24, 24, 27, 29, 455, 455, 23, 456};
  logic [23:0] pr_e[9] = '{24'hFFFFFF, BORDER, BORDER, 24'hAAAAAA, 24'hAAAAAA,
                           24'h000000, BORDER, BORDER, BORDER};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 3; i++) begin
      hx[i] = -1;
      hy[i] = -1;
    end
  endtask

  // after each call fb_addr reflects hx[0] and rgb reflects hx[2]
  task automatic drive(input int x, input int y);
    cx = 10'(x);
    cy = 10'(y);
    @(posedge clk_pixel);
    #1;
    hx[2] = hx[1]; hy[2] = hy[1];
    hx[1] = hx[0]; hy[1] = hy[0];
    hx[0] = x;     hy[0] = y;
    if (fb_if.frame_ack) ack_cnt++;
    if (probes_on) begin
      for (int i = 0; i < 5; i++)
        if (hx[0] == pa_x[i] && hy[0] == pa_y[i])
          check($sformatf("addr(%0d,%0d)", pa_x[i], pa_y[i]), 32'(fb_if.fb_addr), pa_e[i]);
      for (int i = 0; i < 9; i++)
        if (hx[2] == pr_x[i] && hy[2] == pr_y[i])
          check($sformatf("rgb(%0d,%0d)", pr_x[i], pr_y[i]), 32'(rgb), 32'(pr_e[i]));
    end
    if (post_rst && hx[2] >= 80 && hx[2] < 560 && hy[2] >= 24 && hy[2] < 456) begin
      check("post_rst_rgb", 32'(rgb), 32'(BORDER));
      check("post_rst_addr", 32'(fb_if.fb_addr), 32'd0);
    end
  endtask

  task automatic line(input int y, input bit done);
    fb_if.frame_done = done;
    drive(0, y);
    fb_if.frame_done = 1'b0;
    if (y == 455) begin
      for (int x = 78; x <= 562; x++) drive(x, y);
    end else if (y >= 20 && y <= 460) begin
      for (int x = 78; x <= 85; x++) drive(x, y);
    end else begin
      drive(1, y);
      drive(2, y);
    end
  endtask

  task automatic frame(input int d1, input int d2, input bit d_swap, input bit exp_toggle);
    ack_cnt = 0;
    fb_if.frame_done = d_swap;
    drive(0, 0);
    fb_if.frame_done = 1'b0;
    exp_bank = exp_bank ^ exp_toggle;
    check("bank_at_swap", 32'(fb_if.fb_bank), 32'(exp_bank));
    check("ack_at_swap", 32'(fb_if.frame_ack), 32'(exp_toggle));
    drive(1, 0);
    check("ack_after_swap", 32'(fb_if.frame_ack), 32'd0);
    drive(2, 0);
    for (int y = 1; y < 525; y++) line(y, (y == d1) || (y == d2));
    check("ack_count", 32'(ack_cnt), 32'(exp_toggle));
  endtask

  initial begin
    fb_if.frame_done = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_addr", 32'(fb_if.fb_addr), 32'd0);
    check("rst_bank", 32'(fb_if.fb_bank), 32'd0);
    check("rst_ack", 32'(fb_if.frame_ack), 32'd0);
    drive(700, 500);
    drive(701, 500);
    reset_n = 1'b1;
    clear_hist();

    frame(100, -1, 1'b0, 1'b0);
    frame(50, 300, 1'b0, 1'b1);
    frame(-1, -1, 1'b0, 1'b1);
    frame(-1, -1, 1'b1, 1'b1);
    frame(-1, -1, 1'b0, 1'b0);

    // mid-frame reset at cy=200
    probes_on = 1'b0;
    for (int y = 0; y < 200; y++) line(y, 1'b0);
    drive(0, 200);
    for (int x = 78; x <= 85; x++) drive(x, 200);
    reset_n = 1'b0;
    #1;
    check("mid_rst_rgb", 32'(rgb), 32'd0);
    check("mid_rst_addr", 32'(fb_if.fb_addr), 32'd0);
    check("mid_rst_bank", 32'(fb_if.fb_bank), 32'd0);
    check("mid_rst_ack", 32'(fb_if.frame_ack), 32'd0);
    exp_bank = 1'b0;
    drive(86, 200);
    drive(87, 200);
    reset_n = 1'b1;
    clear_hist();
    drive(88, 200);
    drive(89, 200);
    post_rst = 1'b1;
    for (int y = 201; y < 525; y++) line(y, 1'b0);
    post_rst  = 1'b0;
    probes_on = 1'b1;
    frame(-1, -1, 1'b0, 1'b0);

    // palette: data forced to a fixed shade
    probes_on   = 1'b0;
    force_en    = 1'b1;
    force_val   = 2'd2;
    palette_sel = 1'b0;
    drive(0, 100);
    for (int x = 78; x <= 84; x++) drive(x, 100);
    check("pal_grey_2", 32'(rgb), 32'h555555);
    palette_sel = 1'b1;
    drive(85, 100);
    check("pal_toggle_to_dmg", 32'(rgb), 32'h306230);
    drive(86, 100);
    check("pal_dmg_2", 32'(rgb), 32'h306230);
    palette_sel = 1'b0;
    drive(87, 100);
    check("pal_toggle_to_grey", 32'(rgb), 32'h555555);
    force_val   = 2'd0;
    palette_sel = 1'b1;
    drive(88, 100);
    drive(89, 100);
    drive(90, 100);
    check("pal_dmg_0", 32'(rgb), 32'h9BBC0F);
    force_val = 2'd3;
    drive(91, 100);
    drive(92, 100);
    drive(93, 100);
    check("pal_dmg_3", 32'(rgb), 32'h0F380F);
    force_val = 2'd1;
    drive(94, 100);
    drive(95, 100);
    drive(96, 100);
    check("pal_dmg_1", 32'(rgb), 32'h8BAC0F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
